ug_nor_lu: RTL and testbench

- Parametrised, pipelined bitwise logic unit. Every operation is built only from NOR primitives, as a universal-gate successor.
- Operates on WIDTH-bit operands with a valid/ready handshake on input and output.
- Holds an accumulator that a transaction can write and a later transaction can read as operand A, with a hazard interlock.
- Sits between operand producers and a result consumer in the gate-level teaching datapath.

---
 rtl/ug_nor_pkg.sv | 37 +++
 rtl/ug_nor_cell.sv | 55 +++++
 rtl/ug_nor_lu.sv | 104 ++++++++++
 tb/tb_ug_nor_lu.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ug_nor_pkg.sv
`default_nettype none
// ============================================================================
// ug_nor_pkg : op codes, parameter limits and 1-bit NOR helpers for ug_nor_lu
// Rev 1.0
// ============================================================================
package ug_nor_pkg;

  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MAX = 4;

  typedef enum logic [2:0] {
    UG_OP_NOR    = 3'd0,
    UG_OP_OR     = 3'd1,
    UG_OP_AND    = 3'd2,
    UG_OP_NOT    = 3'd3,
    UG_OP_NAND   = 3'd4,
    UG_OP_XOR    = 3'd5,
    UG_OP_XNOR   = 3'd6,
    UG_OP_PASS_B = 3'd7
  } ug_op_t;

  function automatic logic nor1(input logic x, input logic y);
    return ~(x | y);
  endfunction

  // XOR from four NOR cells plus a NOR inverter on the XNOR node.
  function automatic logic xor_nor(input logic x, input logic y);
    logic n, p, q, xn;
    n  = nor1(x, y);
    p  = nor1(x, n);
    q  = nor1(y, n);
    xn = nor1(p, q);
    return nor1(xn, xn);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ug_nor_cell.sv
`default_nettype none
// ============================================================================
// ug_nor_cell : combinational WIDTH-bit logic op built only from 2-input NORs
// Rev 1.0
// ============================================================================
import ug_nor_pkg::*;

module ug_nor_cell #(
  parameter int WIDTH = 8
) (
  input  ug_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  function automatic logic [WIDTH-1:0] nor2(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] z);
    return ~(x | z);
  endfunction

  logic [WIDTH-1:0] n_ab, n_aa, n_bb;
  logic [WIDTH-1:0] f_or, f_and, f_nand, f_passb;
  logic [WIDTH-1:0] x_p, x_q, f_xnor, f_xor;

  assign n_ab    = nor2(a, b);
  assign n_aa    = nor2(a, a);
  assign n_bb    = nor2(b, b);
  assign f_or    = nor2(n_ab, n_ab);
  assign f_and   = nor2(n_aa, n_bb);
  assign f_nand  = nor2(f_and, f_and);
  assign f_passb = nor2(n_bb, n_bb);
  // x_p = ~a&b, x_q = a&~b; their NOR is XNOR.
  assign x_p     = nor2(a, n_ab);
  assign x_q     = nor2(b, n_ab);
  assign f_xnor  = nor2(x_p, x_q);
  assign f_xor   = nor2(f_xnor, f_xnor);

  always_comb begin
    y = n_ab;
    case (op)
      UG_OP_NOR:    y = n_ab;
      UG_OP_OR:     y = f_or;
      UG_OP_AND:    y = f_and;
      UG_OP_NOT:    y = n_aa;
      UG_OP_NAND:   y = f_nand;
      UG_OP_XOR:    y = f_xor;
      UG_OP_XNOR:   y = f_xnor;
      UG_OP_PASS_B: y = f_passb;
      default:      y = n_ab;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ug_nor_lu.sv
`default_nettype none
// ============================================================================
// ug_nor_lu : pipelined NOR-only logic unit with accumulator and hazard lock
// Optional parity output: define UG_NOR_LU_PARITY_EN.   Rev 1.0
// ============================================================================
import ug_nor_pkg::*;

module ug_nor_lu #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             acc_sel,
  input  logic             acc_wr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
`ifdef UG_NOR_LU_PARITY_EN
  output logic             result_par,
`endif
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] ops_count
);

  logic             stall, hazard, accept, retire;
  logic [WIDTH-1:0] op_a, cell_y;
  logic [STAGES-1:0] vld, wrf;
  logic [WIDTH-1:0] dat [STAGES];

  assign out_valid = vld[STAGES-1];
  assign result    = dat[STAGES-1];
  assign stall     = out_valid & ~out_ready;
  // Any in-flight accumulator write blocks an accumulator read.
  assign hazard    = acc_sel & |(vld & wrf);
  assign in_ready  = ~stall & ~hazard;
  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign op_a      = acc_sel ? acc : a;

  ug_nor_cell #(.WIDTH(WIDTH)) u_cell (
    .op (ug_op_t'(op)),
    .a  (op_a),
    .b  (b),
    .y  (cell_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      wrf <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else if (!stall) begin
      vld[0] <= accept;
      wrf[0] <= accept & acc_wr;
      dat[0] <= accept ? cell_y : '0;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        wrf[i] <= wrf[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

`ifdef UG_NOR_LU_PARITY_EN
  logic              par_y;
  logic [STAGES-1:0] par;

  always_comb begin
    par_y = 1'b0;
    for (int i = 0; i < WIDTH; i++) par_y = xor_nor(par_y, cell_y[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      par <= '0;
    end else if (!stall) begin
      par[0] <= accept & par_y;
      for (int i = 1; i < STAGES; i++) par[i] <= par[i-1];
    end
  end

  assign result_par = par[STAGES-1];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      ops_count <= '0;
    end else if (retire) begin
      if (wrf[STAGES-1]) acc <= result;
      if (ops_count != {CNT_W{1'b1}})
        ops_count <= ops_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ug_nor_lu.sv
`default_nettype none
// ============================================================================
// tb_ug_nor_lu : scoreboard bench for ug_nor_lu (directed phases + random)
// Rev 1.0
// ============================================================================
module tb_ug_nor_lu;

  localparam int WIDTH  = 8;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, acc_sel, acc_wr, out_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a, b;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] result, acc;
  logic [15:0]      ops_count;
  logic             s_in_ready, s_out_valid;
  logic [WIDTH-1:0] s_result, s_acc;
  logic [1:0]       s_count;
`ifdef UG_NOR_LU_PARITY_EN
  logic             result_par, s_par;
`endif

  always #5 clk = ~clk;

  ug_nor_lu #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .acc_sel(acc_sel), .acc_wr(acc_wr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
`ifdef UG_NOR_LU_PARITY_EN
    .result_par(result_par),
`endif
    .acc(acc), .ops_count(ops_count)
  );

  ug_nor_lu #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .op(op), .a(a), .b(b), .acc_sel(acc_sel), .acc_wr(acc_wr),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result),
`ifdef UG_NOR_LU_PARITY_EN
    .result_par(s_par),
`endif
    .acc(s_acc), .ops_count(s_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain Boolean meaning of each op code.
  function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] o,
                                              input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y);
    case (o)
      3'd0: return ~(x | y);
      3'd1: return x | y;
      3'd2: return x & y;
      3'd3: return ~x;
      3'd4: return ~(x & y);
      3'd5: return x ^ y;
      3'd6: return ~(x ^ y);
      default: return y;
    endcase
  endfunction

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             wr;
    int               cyc;
  } ent_t;

  ent_t             q[$];
  logic [WIDTH-1:0] acc_model = '0;
  int               retired = 0;
  int               cycle = 0;
  bit               lat_mode = 0;
  bit               prev_stall = 0;
  logic [WIDTH-1:0] prev_result = '0;
  logic [WIDTH-1:0] last_ret = '0;

  always @(posedge clk) cycle++;

  // Scoreboard: observes mid-cycle what the next rising edge will do.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      acc_model  = '0;
      retired    = 0;
      prev_stall = 0;
    end else begin
      bit pend_wr;
      pend_wr = 0;
      foreach (q[i]) if (q[i].wr) pend_wr = 1;
      check("in_ready", in_ready, !(out_valid && !out_ready) && !(acc_sel && pend_wr));
      if (q.size() == 0) check("idle_out_valid", out_valid, 1'b0);
      check("acc", acc, acc_model);
      check("ops_count", ops_count, retired);
      check("sat_count", s_count, (retired > 3) ? 3 : retired);
      if (prev_stall) check("stall_hold", result, prev_result);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_retire", 1'b1, 1'b0);
        end else begin
          ent_t h;
          h = q.pop_front();
          check("result", result, h.res);
`ifdef UG_NOR_LU_PARITY_EN
          check("result_par", result_par, ^h.res);
`endif
          if (lat_mode) check("latency", cycle - h.cyc, STAGES);
          if (h.wr) acc_model = h.res;
          last_ret = result;
          retired++;
        end
      end
      if (in_valid && in_ready) begin
        ent_t e;
        e.res = ref_op(op, acc_sel ? acc_model : a, b);
        e.wr  = acc_wr;
        e.cyc = cycle;
        q.push_back(e);
      end
      prev_stall  = out_valid && !out_ready;
      prev_result = result;
    end
  end

  task automatic send(input logic [2:0] o, input logic [WIDTH-1:0] xa,
                      input logic [WIDTH-1:0] xb, input logic sel, input logic wr);
    bit ok;
    ok = 0;
    in_valid = 1'b1; op = o; a = xa; b = xb; acc_sel = sel; acc_wr = wr;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!ok) check("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    if (!ok) check("drain_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0;
    acc_sel = 1'b0; acc_wr = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_result", result, '0);
    check("rst_acc", acc, '0);
    check("rst_count", ops_count, '0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // All eight ops back-to-back, fixed operands, latency checked.
    lat_mode = 1;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'hCC, 1'b0, 1'b0);
    drain();
    lat_mode = 0;
    check("op_cov_count", ops_count, 16'd8);
    check("op_cov_last", last_ret, 8'hCC);

    // Backpressure: consumer stalls for 4 cycles mid-stream.
    base = retired;
    fork
      for (int i = 0; i < 6; i++) send(3'(i), 8'h5A + 8'(i), 8'h3C, 1'b0, 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", ops_count, 16'(base + 6));

    // Accumulator interlock.
    send(3'd1, 8'h01, 8'h02, 1'b0, 1'b1);
    send(3'd5, 8'hAA, 8'hFF, 1'b1, 1'b0);
    drain();
    check("lock_acc", acc, 8'h03);
    check("lock_result", last_ret, 8'hFC);

`ifdef UG_NOR_LU_PARITY_EN
    send(3'd2, 8'hFF, 8'h07, 1'b0, 1'b0);
    drain();
    check("par_result", last_ret, 8'h07);
`endif

    // Reset with two transactions in flight.
    out_ready = 1'b0;
    send(3'd1, 8'h11, 8'h22, 1'b0, 1'b1);
    send(3'd2, 8'h33, 8'h44, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_acc", acc, '0);
    check("mid_rst_count", ops_count, '0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    repeat (4) @(posedge clk);
    #1;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      op        = 3'($urandom_range(0, 7));
      a         = 8'($urandom);
      b         = 8'($urandom);
      acc_sel   = ($urandom_range(0, 99) < 30);
      acc_wr    = ($urandom_range(0, 99) < 30);
      out_ready = ($urandom_range(0, 99) < 70);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    check("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
